cafeteira_multidose: RTL and testbench
======================================

Name: cafeteira_multidose

Overview:
- Self-contained successor to the single-cup coffee controller.
- Brews 1..MAX_DOSES cups per request. Before every dose it re-checks the water level and cup presence.
- Consumes distance words from external ultrasonic interface blocks, times the pump and valve internally, and bounds boiler heating with a timeout.
- Sits between the serial/ESP command decoder (preparar, doses, cancelar) and the actuator drivers.

Parameters:
- DIST_W, 12, width of distance words.
- DOSE_W, 3, width of doses request.
- MAX_DOSES, 4, largest accepted dose count.
- AGUA_LIMITE, 100, dist_agua <= this means sufficient water.
- XICARA_LIMITE, 20, dist_xicara <= this means cup present.
- MEDIDA_TIMEOUT, 50000, cycles to wait for a sensor result.
- BOMBA_TICKS, 100000, cycles the pump runs per dose.
- EBULIDOR_TIMEOUT, 500000, maximum heating cycles.
- VALVULA_TICKS, 80000, cycles the valve opens per dose.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- preparar  in  1  start request, level-sampled
- doses  in  DOSE_W  cup count, sampled when preparar is accepted
- cancelar  in  1  abort request
- medida_agua_pronto  in  1  dist_agua valid, 1-cycle pulse
- dist_agua  in  DIST_W  water-surface distance
- medida_xicara_pronto  in  1  dist_xicara valid, 1-cycle pulse
- dist_xicara  in  DIST_W  cup distance
- fim_temperatura  in  1  boiler reached temperature
- medir_agua  out  1  1-cycle trigger to water sensor
- medir_xicara  out  1  1-cycle trigger to cup sensor
- bomba  out  1  pump on
- ebulidor  out  1  boiler on
- valvula  out  1  valve open
- erro_sem_agua  out  1  latched error
- erro_sem_xicara  out  1  latched error
- erro_ebulidor  out  1  latched heating-timeout error
- ocupado  out  1  not in INICIAL/ERRO
- pronto  out  1  1-cycle pulse when all doses are done
- dose_atual  out  DOSE_W  doses completed in current request
- db_estado  out  4  state code

Behaviour:
- Reset (reset=0, async): state INICIAL, all outputs 0, counters and latched doses cleared.
- Outputs are Moore, decoded from the registered state. Exactly one internal timer, cleared on every state entry.
- State codes (db_estado): INICIAL=0, PREPARA=1, DISPARA_AGUA=2, ESPERA_AGUA=3, DISPARA_XICARA=4, ESPERA_XICARA=5, BOMBA=6, AQUECE=7, VALVULA=8, PROXIMA=9, FIM=10, ERRO=15.
- INICIAL/ERRO -> PREPARA on preparar=1 with 1<=doses<=MAX_DOSES.
  - The request latches doses and clears dose_atual and all error flags.
  - doses=0 or doses>MAX_DOSES: ignored; state and error flags unchanged.
- PREPARA -> DISPARA_AGUA (1 cycle).
- DISPARA_AGUA: medir_agua=1 for this single cycle, then ESPERA_AGUA.
- ESPERA_AGUA:
  - On medida_agua_pronto: if dist_agua<=AGUA_LIMITE go DISPARA_XICARA, else set erro_sem_agua and go ERRO.
  - Timer reaching MEDIDA_TIMEOUT without pronto: set erro_sem_agua, go ERRO.
  - pronto and timeout in the same cycle: pronto wins.
- DISPARA_XICARA and ESPERA_XICARA: identical structure using medir_xicara, dist_xicara, XICARA_LIMITE and erro_sem_xicara; success goes to BOMBA.
- BOMBA: bomba=1 for exactly BOMBA_TICKS cycles, then AQUECE.
- AQUECE: ebulidor=1.
  - fim_temperatura=1 -> VALVULA.
  - EBULIDOR_TIMEOUT cycles elapsed -> set erro_ebulidor, go ERRO.
  - fim_temperatura wins over a simultaneous timeout.
- VALVULA: valvula=1 for exactly VALVULA_TICKS cycles, then PROXIMA.
- PROXIMA: dose_atual+1 (1 cycle). If the new value equals the latched doses go FIM, else DISPARA_AGUA, so water and cup are re-checked per dose.
- FIM: pronto=1 for 1 cycle, then INICIAL. dose_atual holds its final value until the next accepted request.
- ERRO:
  - All actuators 0; error flags held.
  - dose_atual holds the count of completed doses.
  - Only preparar (valid) leaves ERRO.
- cancelar=1 in any state except INICIAL/ERRO:
  - Next state is INICIAL; all actuators are 0 from the next cycle.
  - No error flag set, no pronto pulse.
  - cancelar has priority over every other transition, including a simultaneous timer expiry.
- cancelar in INICIAL/ERRO has no effect. If preparar is also high in that cycle, the request is still accepted.
- preparar while ocupado=1 is ignored.
- At most one actuator is high in any cycle. bomba and ebulidor are never simultaneously 1.
- Timer width: clog2 of the largest tick parameter plus 1. Comparisons are unsigned.

Test Plan (params: AGUA_LIMITE=100, XICARA_LIMITE=20, MEDIDA_TIMEOUT=8, BOMBA_TICKS=4, EBULIDOR_TIMEOUT=10, VALVULA_TICKS=3, MAX_DOSES=3):
- Two doses, happy path: preparar with doses=2; sensors answer dist_agua=50, dist_xicara=10; fim_temperatura 3 cycles into AQUECE.
  - Required: two medir_agua pulses; bomba high 4 cycles twice; valvula high 3 cycles twice; pronto 1 cycle; dose_atual=2.
- Dry tank on second dose: doses=3, second dist_agua=150.
  - Required: erro_sem_agua=1, state 15, dose_atual=1, no bomba after the first dose.
- Missing cup: dose 1 gets no medida_xicara_pronto.
  - Required: erro_sem_xicara rises exactly 8 cycles after entering ESPERA_XICARA; all actuators 0.
- Boiler timeout: fim_temperatura held 0.
  - Required: ebulidor high exactly 10 cycles, then erro_ebulidor=1, ebulidor=0.
- Cancel and invalid requests:
  - cancelar at the 2nd BOMBA cycle: bomba=0 next cycle, state 0, no error, no pronto.
  - preparar with doses=0 and doses=4: no state change.
- Async reset mid-VALVULA (reset=0 between edges): valvula=0 immediately, dose_atual=0, db_estado=0.
- Restart from ERRO: a valid preparar clears all error flags and dose_atual.

Source files
------------

// File: rtl/cafeteira_multidose.sv
// rtl/cafeteira_multidose.sv - multi-dose coffee machine controller
//
// Brews 1..MAX_DOSES cups per request, re-checking water level and cup
// presence before every dose, then running pump, boiler and valve in turn.
//
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   preparar, doses         start request and cup count (sampled on accept)
//   cancelar                abort the current request
//   medida_agua_pronto,
//   dist_agua               water-surface distance and its 1-cycle strobe
//   medida_xicara_pronto,
//   dist_xicara             cup distance and its 1-cycle strobe
//   fim_temperatura         boiler reached temperature
//   medir_agua, medir_xicara 1-cycle sensor triggers
//   bomba, ebulidor, valvula actuator enables (one-hot or idle)
//   erro_sem_agua, erro_sem_xicara, erro_ebulidor  latched error flags
//   ocupado                 request in progress (not INICIAL/ERRO)
//   pronto                  1-cycle pulse when all doses are done
//   dose_atual              doses completed in the current request
//   db_estado               state code

module cafeteira_multidose #(
  parameter int DIST_W           = 12,
  parameter int DOSE_W           = 3,
  parameter int MAX_DOSES        = 4,
  parameter int AGUA_LIMITE      = 100,
  parameter int XICARA_LIMITE    = 20,
  parameter int MEDIDA_TIMEOUT   = 50000,
  parameter int BOMBA_TICKS      = 100000,
  parameter int EBULIDOR_TIMEOUT = 500000,
  parameter int VALVULA_TICKS    = 80000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              preparar,
  input  logic [DOSE_W-1:0] doses,
  input  logic              cancelar,
  input  logic              medida_agua_pronto,
  input  logic [DIST_W-1:0] dist_agua,
  input  logic              medida_xicara_pronto,
  input  logic [DIST_W-1:0] dist_xicara,
  input  logic              fim_temperatura,
  output logic              medir_agua,
  output logic              medir_xicara,
  output logic              bomba,
  output logic              ebulidor,
  output logic              valvula,
  output logic              erro_sem_agua,
  output logic              erro_sem_xicara,
  output logic              erro_ebulidor,
  output logic              ocupado,
  output logic              pronto,
  output logic [DOSE_W-1:0] dose_atual,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    DISPARA_AGUA   = 4'd2,
    ESPERA_AGUA    = 4'd3,
    DISPARA_XICARA = 4'd4,
    ESPERA_XICARA  = 4'd5,
    BOMBA          = 4'd6,
    AQUECE         = 4'd7,
    VALVULA        = 4'd8,
    PROXIMA        = 4'd9,
    FIM            = 4'd10,
    ERRO           = 4'd15
  } estado_t;

  localparam int MAX_A = (MEDIDA_TIMEOUT > BOMBA_TICKS) ? MEDIDA_TIMEOUT : BOMBA_TICKS;
  localparam int MAX_B = (EBULIDOR_TIMEOUT > VALVULA_TICKS) ? EBULIDOR_TIMEOUT : VALVULA_TICKS;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T) + 1;

  // The timer reads 0 in the first cycle of a state, so a phase lasting N
  // cycles ends when the timer shows N-1.
  localparam logic [TW-1:0] MEDIDA_LAST = TW'(MEDIDA_TIMEOUT - 1);
  localparam logic [TW-1:0] BOMBA_LAST  = TW'(BOMBA_TICKS - 1);
  localparam logic [TW-1:0] EBUL_LAST   = TW'(EBULIDOR_TIMEOUT - 1);
  localparam logic [TW-1:0] VALV_LAST   = TW'(VALVULA_TICKS - 1);

  localparam logic [DIST_W-1:0] AGUA_LIM   = DIST_W'(AGUA_LIMITE);
  localparam logic [DIST_W-1:0] XICARA_LIM = DIST_W'(XICARA_LIMITE);
  localparam logic [DOSE_W-1:0] MAX_D      = DOSE_W'(MAX_DOSES);

  estado_t           estado, estado_prox;
  logic [TW-1:0]     timer;
  logic [DOSE_W-1:0] doses_lat;
  logic [DOSE_W-1:0] dose_q;
  logic [DOSE_W-1:0] dose_inc;
  logic              erro_agua_q, erro_xicara_q, erro_ebul_q;
  logic              ocioso, aceita, cancela;
  logic              set_agua, set_xicara, set_ebul;

  assign ocioso   = (estado == INICIAL) || (estado == ERRO);
  assign aceita   = ocioso && preparar && (doses != '0) && (doses <= MAX_D);
  assign cancela  = cancelar && !ocioso;
  assign dose_inc = dose_q + DOSE_W'(1);

  always_comb begin
    estado_prox = estado;
    set_agua    = 1'b0;
    set_xicara  = 1'b0;
    set_ebul    = 1'b0;
    if (cancela) begin
      estado_prox = INICIAL;
    end else begin
      case (estado)
        INICIAL, ERRO: if (aceita) estado_prox = PREPARA;
        PREPARA:       estado_prox = DISPARA_AGUA;
        DISPARA_AGUA:  estado_prox = ESPERA_AGUA;
        ESPERA_AGUA: begin
          if (medida_agua_pronto) begin
            if (dist_agua <= AGUA_LIM) begin
              estado_prox = DISPARA_XICARA;
            end else begin
              set_agua    = 1'b1;
              estado_prox = ERRO;
            end
          end else if (timer == MEDIDA_LAST) begin
            set_agua    = 1'b1;
            estado_prox = ERRO;
          end
        end
        DISPARA_XICARA: estado_prox = ESPERA_XICARA;
        ESPERA_XICARA: begin
          if (medida_xicara_pronto) begin
            if (dist_xicara <= XICARA_LIM) begin
              estado_prox = BOMBA;
            end else begin
              set_xicara  = 1'b1;
              estado_prox = ERRO;
            end
          end else if (timer == MEDIDA_LAST) begin
            set_xicara  = 1'b1;
            estado_prox = ERRO;
          end
        end
        BOMBA: if (timer == BOMBA_LAST) estado_prox = AQUECE;
        AQUECE: begin
          if (fim_temperatura) begin
            estado_prox = VALVULA;
          end else if (timer == EBUL_LAST) begin
            set_ebul    = 1'b1;
            estado_prox = ERRO;
          end
        end
        VALVULA: if (timer == VALV_LAST) estado_prox = PROXIMA;
        PROXIMA: estado_prox = (dose_inc == doses_lat) ? FIM : DISPARA_AGUA;
        FIM:     estado_prox = INICIAL;
        default: estado_prox = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= INICIAL;
      timer         <= '0;
      doses_lat     <= '0;
      dose_q        <= '0;
      erro_agua_q   <= 1'b0;
      erro_xicara_q <= 1'b0;
      erro_ebul_q   <= 1'b0;
    end else begin
      estado <= estado_prox;
      // Single shared timer; idle states keep it parked at zero.
      if ((estado_prox != estado) || ocioso) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
      if (aceita) begin
        doses_lat     <= doses;
        dose_q        <= '0;
        erro_agua_q   <= 1'b0;
        erro_xicara_q <= 1'b0;
        erro_ebul_q   <= 1'b0;
      end else begin
        if ((estado == PROXIMA) && !cancela) dose_q <= dose_inc;
        if (set_agua)   erro_agua_q   <= 1'b1;
        if (set_xicara) erro_xicara_q <= 1'b1;
        if (set_ebul)   erro_ebul_q   <= 1'b1;
      end
    end
  end

  assign medir_agua      = (estado == DISPARA_AGUA);
  assign medir_xicara    = (estado == DISPARA_XICARA);
  assign bomba           = (estado == BOMBA);
  assign ebulidor        = (estado == AQUECE);
  assign valvula         = (estado == VALVULA);
  assign pronto          = (estado == FIM);
  assign ocupado         = !ocioso;
  assign erro_sem_agua   = erro_agua_q;
  assign erro_sem_xicara = erro_xicara_q;
  assign erro_ebulidor   = erro_ebul_q;
  assign dose_atual      = dose_q;
  assign db_estado       = estado;

endmodule

// File: tb/tb_cafeteira_multidose.sv
// tb/tb_cafeteira_multidose.sv - scoreboard bench for cafeteira_multidose

module tb_cafeteira_multidose;

  logic        clock = 1'b0;
  logic        reset;
  logic        preparar;
  logic [2:0]  doses;
  logic        cancelar;
  logic        medida_agua_pronto;
  logic [11:0] dist_agua;
  logic        medida_xicara_pronto;
  logic [11:0] dist_xicara;
  logic        fim_temperatura;
  logic        medir_agua, medir_xicara, bomba, ebulidor, valvula;
  logic        erro_sem_agua, erro_sem_xicara, erro_ebulidor;
  logic        ocupado, pronto;
  logic [2:0]  dose_atual;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  cafeteira_multidose #(
    .DIST_W(12), .DOSE_W(3), .MAX_DOSES(3), .AGUA_LIMITE(100), .XICARA_LIMITE(20),
    .MEDIDA_TIMEOUT(8), .BOMBA_TICKS(4), .EBULIDOR_TIMEOUT(10), .VALVULA_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .preparar(preparar), .doses(doses),
    .cancelar(cancelar), .medida_agua_pronto(medida_agua_pronto),
    .dist_agua(dist_agua), .medida_xicara_pronto(medida_xicara_pronto),
    .dist_xicara(dist_xicara), .fim_temperatura(fim_temperatura),
    .medir_agua(medir_agua), .medir_xicara(medir_xicara), .bomba(bomba),
    .ebulidor(ebulidor), .valvula(valvula), .erro_sem_agua(erro_sem_agua),
    .erro_sem_xicara(erro_sem_xicara), .erro_ebulidor(erro_ebulidor),
    .ocupado(ocupado), .pronto(pronto), .dose_atual(dose_atual),
    .db_estado(db_estado)
  );

  // Per-request summary observed while ocupado is high; emitted when it falls.
  typedef struct packed {
    logic [7:0] st, dose, err, pr, ma, mx, bc, br, vc, vr, ec, xw, ovl;
  } rec_t;

  rec_t        exp_q[$];
  string       name_q[$];
  logic [11:0] agua_q[$];
  logic [11:0] xic_q[$];
  int          fim_after = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic string fmt(rec_t r);
    return $sformatf("st=%0d dose=%0d err=%b pronto=%0d medir_agua=%0d medir_xic=%0d bomba=%0d/%0d valv=%0d/%0d ebul=%0d esp_xic=%0d overlap=%0d",
                     r.st, r.dose, r.err[2:0], r.pr, r.ma, r.mx, r.bc, r.br, r.vc, r.vr, r.ec, r.xw, r.ovl);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic expect_rec(string nm, int st, int dose, int err, int pr, int ma, int mx,
                            int bc, int br, int vc, int vr, int ec, int xw);
    rec_t r;
    r.st = 8'(st);  r.dose = 8'(dose); r.err = 8'(err); r.pr = 8'(pr);
    r.ma = 8'(ma);  r.mx = 8'(mx);     r.bc = 8'(bc);   r.br = 8'(br);
    r.vc = 8'(vc);  r.vr = 8'(vr);     r.ec = 8'(ec);   r.xw = 8'(xw);
    r.ovl = 8'd0;
    exp_q.push_back(r);
    name_q.push_back(nm);
  endtask

  // Monitor: accumulates activity of a request and scores it at its end.
  initial begin
    rec_t acc, e;
    string nm;
    logic prev_ocup, prev_b, prev_v;
    int nact;
    acc = '0; prev_ocup = 1'b0; prev_b = 1'b0; prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (ocupado) begin
        if (pronto)       acc.pr = acc.pr + 8'd1;
        if (medir_agua)   acc.ma = acc.ma + 8'd1;
        if (medir_xicara) acc.mx = acc.mx + 8'd1;
        if (bomba)        acc.bc = acc.bc + 8'd1;
        if (bomba && !prev_b)   acc.br = acc.br + 8'd1;
        if (valvula)      acc.vc = acc.vc + 8'd1;
        if (valvula && !prev_v) acc.vr = acc.vr + 8'd1;
        if (ebulidor)     acc.ec = acc.ec + 8'd1;
        if (db_estado == 4'd5) acc.xw = acc.xw + 8'd1;
        nact = int'(bomba) + int'(ebulidor) + int'(valvula);
        if (nact > 1)     acc.ovl = acc.ovl + 8'd1;
      end
      if (prev_ocup && !ocupado) begin
        acc.st   = 8'(db_estado);
        acc.dose = 8'(dose_atual);
        acc.err  = {5'd0, erro_sem_agua, erro_sem_xicara, erro_ebulidor};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_request_end: got %s expected none", fmt(acc));
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (acc !== e) begin
            n_bad++;
            $display("FAIL %s: got %s expected %s", nm, fmt(acc), fmt(e));
          end
        end
        acc = '0;
      end
      prev_b    = bomba;
      prev_v    = valvula;
      prev_ocup = ocupado;
    end
  end

  // Water sensor model: answers one cycle after the trigger.
  initial begin
    medida_agua_pronto = 1'b0;
    dist_agua = '0;
    forever begin
      @(negedge clock);
      if (medir_agua && agua_q.size() > 0) begin
        dist_agua = agua_q.pop_front();
        @(negedge clock);
        medida_agua_pronto = 1'b1;
        @(negedge clock);
        medida_agua_pronto = 1'b0;
      end
    end
  end

  // Cup sensor model: silent when its queue is empty.
  initial begin
    medida_xicara_pronto = 1'b0;
    dist_xicara = '0;
    forever begin
      @(negedge clock);
      if (medir_xicara && xic_q.size() > 0) begin
        dist_xicara = xic_q.pop_front();
        @(negedge clock);
        medida_xicara_pronto = 1'b1;
        @(negedge clock);
        medida_xicara_pronto = 1'b0;
      end
    end
  end

  // Boiler model: temperature reached in the fim_after-th heating cycle (0 = never).
  initial begin
    int ebul_run;
    ebul_run = 0;
    fim_temperatura = 1'b0;
    forever begin
      @(negedge clock);
      if (ebulidor) begin
        ebul_run++;
        fim_temperatura = (fim_after != 0) && (ebul_run == fim_after);
      end else begin
        ebul_run = 0;
        fim_temperatura = 1'b0;
      end
    end
  end

  task automatic request(int d);
    @(negedge clock);
    preparar = 1'b1;
    doses    = 3'(d);
    @(negedge clock);
    preparar = 1'b0;
    doses    = '0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int k = 0;
    while (ocupado && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (ocupado) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, budget);
    end
  endtask

  task automatic wait_act(string nm, int which, int budget);
    int k = 0;
    logic hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge clock);
      k++;
      hit = (which == 0) ? bomba : valvula;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no actuator within %0d cycles expected high", nm, budget);
    end
  endtask

  task automatic load(logic [11:0] a0, logic [11:0] a1, int na, logic [11:0] x0, logic [11:0] x1, int nx);
    agua_q.delete();
    xic_q.delete();
    if (na > 0) agua_q.push_back(a0);
    if (na > 1) agua_q.push_back(a1);
    if (nx > 0) xic_q.push_back(x0);
    if (nx > 1) xic_q.push_back(x1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; preparar = 1'b0; doses = '0; cancelar = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {20'd0, medir_agua, medir_xicara, bomba, ebulidor, valvula,
                            erro_sem_agua, erro_sem_xicara, erro_ebulidor, ocupado, pronto,
                            dose_atual, db_estado}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    request(0);
    check("doses0_ignored", {27'd0, ocupado, db_estado}, 32'd0);
    request(4);
    check("doses4_ignored", {27'd0, ocupado, db_estado}, 32'd0);

    // Two doses, everything available.
    fim_after = 3;
    load(12'd50, 12'd50, 2, 12'd10, 12'd10, 2);
    expect_rec("happy_two_doses", 0, 2, 3'b000, 1, 2, 2, 8, 2, 6, 2, 6, 2);
    request(2);
    wait_idle("happy", 300);
    repeat (2) @(negedge clock);

    // Tank runs dry before the second dose.
    load(12'd50, 12'd150, 2, 12'd10, 12'd0, 1);
    expect_rec("dry_second_dose", 15, 1, 3'b100, 0, 2, 1, 4, 1, 3, 1, 3, 1);
    request(3);
    wait_idle("dry", 300);
    repeat (2) @(negedge clock);

    // Restart from ERRO, then no cup answers.
    load(12'd50, 12'd0, 1, 12'd0, 12'd0, 0);
    expect_rec("missing_cup", 15, 0, 3'b010, 0, 1, 1, 0, 0, 0, 0, 0, 8);
    request(1);
    check("restart_clears", {25'd0, erro_sem_agua, erro_sem_xicara, erro_ebulidor,
                             dose_atual, db_estado}, {25'd0, 3'b000, 3'd0, 4'd1});
    wait_idle("missing_cup", 300);
    repeat (2) @(negedge clock);

    // Boiler never reaches temperature.
    fim_after = 0;
    load(12'd50, 12'd0, 1, 12'd10, 12'd0, 1);
    expect_rec("boiler_timeout", 15, 0, 3'b001, 0, 1, 1, 4, 1, 0, 0, 10, 1);
    request(1);
    wait_idle("boiler", 300);
    repeat (2) @(negedge clock);

    // Cancel in the second pump cycle.
    fim_after = 3;
    load(12'd50, 12'd0, 1, 12'd10, 12'd0, 1);
    expect_rec("cancel_in_bomba", 0, 0, 3'b000, 0, 1, 1, 2, 1, 0, 0, 0, 1);
    request(2);
    wait_act("cancel", 0, 100);
    @(negedge clock);
    cancelar = 1'b1;
    @(negedge clock);
    cancelar = 1'b0;
    check("cancel_stops", {20'd0, bomba, ebulidor, valvula, pronto, ocupado, erro_sem_agua,
                           erro_sem_xicara, erro_ebulidor, db_estado}, 32'd0);
    repeat (2) @(negedge clock);

    // Asynchronous reset while the valve is open.
    load(12'd50, 12'd0, 1, 12'd10, 12'd0, 1);
    expect_rec("reset_in_valvula", 0, 0, 3'b000, 0, 1, 1, 4, 1, 1, 1, 3, 1);
    request(1);
    wait_act("reset_valv", 1, 100);
    #2 reset = 1'b0;
    #1 check("async_reset", {24'd0, valvula, dose_atual, db_estado}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
